// File: rtl/switch_bounce_pkg.sv
// Shared types and LFSR step function for the switch-bounce emulator and
// other stimulus generators that reuse the same pseudo-random source.
package switch_bounce_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        BOUNCE = 1'b1
    } bounce_state_t;

    localparam int                    LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 16'hB400;

    // One step of a right-shifting Galois LFSR.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] cur);
        logic [LFSR_WIDTH-1:0] nxt;
        nxt = {1'b0, cur[LFSR_WIDTH-1:1]};
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/switch_bounce_generator_lfsr.sv
// Free-running 16-bit Galois LFSR; an all-zero seed would lock up, so it is
// replaced by 16'h0001.
module bounce_lfsr16
    import switch_bounce_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] SEED = 16'hACE1
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [LFSR_WIDTH-1:0] state
);

    localparam logic [LFSR_WIDTH-1:0] SEED_NZ = (SEED == '0) ? 16'h0001 : SEED;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= SEED_NZ;
        end else begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/switch_bounce_generator.sv
// Turns a clean synchronous level into a bouncing output: each level change
// produces a burst of pseudo-random toggles for a window, then settles.
module switch_bounce_generator
    import switch_bounce_pkg::*;
#(
    parameter int                    CLOCK_HZ          = 12_000_000,
    parameter int                    MAX_WINDOW_CYCLES = CLOCK_HZ / 100 - 1,
    parameter int                    WINDOW_BITS       = $clog2(MAX_WINDOW_CYCLES + 1),
    parameter int                    MIN_PULSE_CYCLES  = 16,
    parameter int                    PULSE_BITS        = 8,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED         = 16'hACE1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clean_in,
    input  logic [WINDOW_BITS-1:0] bounce_cycles,
    output logic                   bounce_out,
    output logic                   busy,
    output logic                   settled,
    output logic [7:0]             edge_count,
    output bounce_state_t          debug_state
);

    localparam int PULSE_CNT_BITS = $clog2(MIN_PULSE_CYCLES + (1 << PULSE_BITS)) + 1;
    localparam logic [WINDOW_BITS-1:0]    MAX_WINDOW = WINDOW_BITS'(MAX_WINDOW_CYCLES);
    localparam logic [PULSE_CNT_BITS-1:0] PULSE_ONE  = PULSE_CNT_BITS'(1);
    localparam logic [WINDOW_BITS-1:0]    WINDOW_ONE = WINDOW_BITS'(1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    bounce_state_t             state;
    logic                      stable;
    logic                      target;
    logic [WINDOW_BITS-1:0]    window;
    logic [PULSE_CNT_BITS-1:0] pulse_cnt;
    logic [LFSR_WIDTH-1:0]     lfsr_state;
    logic [WINDOW_BITS-1:0]    window_clamped;
    logic [PULSE_CNT_BITS-1:0] interval;
    logic                      unused_lfsr_bits;

    bounce_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clock (clock),
        .reset (reset),
        .state (lfsr_state)
    );

    assign window_clamped   = (bounce_cycles > MAX_WINDOW) ? MAX_WINDOW : bounce_cycles;
    assign interval         = PULSE_CNT_BITS'(MIN_PULSE_CYCLES)
                            + PULSE_CNT_BITS'(lfsr_state[PULSE_BITS-1:0]);
    assign unused_lfsr_bits = ^lfsr_state;
    assign debug_state      = state;

    // A toggle lands when pulse_cnt would reach zero, so consecutive toggles
    // are exactly one interval apart; the last window cycle always forces
    // the target level, overriding any pending toggle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            bounce_out <= 1'b0;
            busy       <= 1'b0;
            settled    <= 1'b0;
            edge_count <= 8'd0;
            stable     <= 1'b0;
            target     <= 1'b0;
            window     <= '0;
            pulse_cnt  <= '0;
        end else begin
            settled <= 1'b0;
            case (state)
                IDLE: begin
                    if (clean_in != stable) begin
                        target     <= clean_in;
                        bounce_out <= clean_in;
                        edge_count <= 8'd1;
                        if (window_clamped == '0) begin
                            stable  <= clean_in;
                            settled <= 1'b1;
                        end else begin
                            window    <= window_clamped;
                            pulse_cnt <= interval;
                            busy      <= 1'b1;
                            state     <= BOUNCE;
                        end
                    end
                end
                BOUNCE: begin
                    window    <= window - 1'b1;
                    pulse_cnt <= pulse_cnt - 1'b1;
                    if (window == WINDOW_ONE) begin
                        bounce_out <= target;
                        if (bounce_out != target) begin
                            edge_count <= sat_inc(edge_count);
                        end
                        stable  <= target;
                        busy    <= 1'b0;
                        settled <= 1'b1;
                        state   <= IDLE;
                    end else if (pulse_cnt <= PULSE_ONE) begin
                        bounce_out <= ~bounce_out;
                        edge_count <= sat_inc(edge_count);
                        pulse_cnt  <= interval;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_bounce_generator.sv
// Directed bench for switch_bounce_generator: settle events are predicted into
// a queue when stimulus is applied and checked when settled pulses.
module tb_switch_bounce_generator;
    import switch_bounce_pkg::*;

    localparam int MAIN_MAX  = 2047;
    localparam int MAIN_WB   = 11;
    localparam int MIN_PULSE = 16;
    localparam int SAT_MAX   = 600;
    localparam int SAT_WB    = 10;
    localparam int EXP_W     = 49;

    logic               clock = 1'b0;
    logic               reset;
    logic               clean_in;
    logic [MAIN_WB-1:0] bounce_cycles;
    logic               bounce_out, busy, settled;
    logic [7:0]         edge_count;
    bounce_state_t      debug_state;

    logic               s0_bounce_out, s0_busy, s0_settled;
    logic [7:0]         s0_edge_count;
    bounce_state_t      s0_state;
    logic               s1_bounce_out, s1_busy, s1_settled;
    logic [7:0]         s1_edge_count;
    bounce_state_t      s1_state;

    logic               clean_in_sat;
    logic [SAT_WB-1:0]  bounce_cycles_sat;
    logic               sat_bounce_out, sat_busy, sat_settled;
    logic [7:0]         sat_edge_count;
    bounce_state_t      sat_state;

    logic [EXP_W-1:0]   exp_q[$];
    int                 n_vec = 0;
    int                 n_err = 0;
    int                 cyc = 0;
    int                 seed_diffs = 0;

    switch_bounce_generator #(.MAX_WINDOW_CYCLES(MAIN_MAX), .WINDOW_BITS(MAIN_WB),
        .MIN_PULSE_CYCLES(MIN_PULSE), .PULSE_BITS(8), .LFSR_SEED(16'hACE1)) dut (
        .clock(clock), .reset(reset), .clean_in(clean_in), .bounce_cycles(bounce_cycles),
        .bounce_out(bounce_out), .busy(busy), .settled(settled),
        .edge_count(edge_count), .debug_state(debug_state));

    switch_bounce_generator #(.MAX_WINDOW_CYCLES(MAIN_MAX), .WINDOW_BITS(MAIN_WB),
        .MIN_PULSE_CYCLES(MIN_PULSE), .PULSE_BITS(8), .LFSR_SEED(16'h0000)) dut_s0 (
        .clock(clock), .reset(reset), .clean_in(clean_in), .bounce_cycles(bounce_cycles),
        .bounce_out(s0_bounce_out), .busy(s0_busy), .settled(s0_settled),
        .edge_count(s0_edge_count), .debug_state(s0_state));

    switch_bounce_generator #(.MAX_WINDOW_CYCLES(MAIN_MAX), .WINDOW_BITS(MAIN_WB),
        .MIN_PULSE_CYCLES(MIN_PULSE), .PULSE_BITS(8), .LFSR_SEED(16'h0001)) dut_s1 (
        .clock(clock), .reset(reset), .clean_in(clean_in), .bounce_cycles(bounce_cycles),
        .bounce_out(s1_bounce_out), .busy(s1_busy), .settled(s1_settled),
        .edge_count(s1_edge_count), .debug_state(s1_state));

    switch_bounce_generator #(.MAX_WINDOW_CYCLES(SAT_MAX), .WINDOW_BITS(SAT_WB),
        .MIN_PULSE_CYCLES(1), .PULSE_BITS(1), .LFSR_SEED(16'hACE1)) dut_sat (
        .clock(clock), .reset(reset), .clean_in(clean_in_sat), .bounce_cycles(bounce_cycles_sat),
        .bounce_out(sat_bounce_out), .busy(sat_busy), .settled(sat_settled),
        .edge_count(sat_edge_count), .debug_state(sat_state));

    // Clock and cycle counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic level, input int settle_at, input int busy_n);
        exp_q.push_back({level, busy_n[15:0], settle_at});
    endtask

    task automatic wait_settled(input int limit, input string tag);
        int got = 0;
        for (int i = 0; i < limit && got == 0; i++) begin
            tick();
            if (settled === 1'b1) got = 1;
        end
        chk(tag, got, 1);
    endtask

    // Monitor: toggle spacing, busy length and settle-time scoreboard
    initial begin
        logic             prev_out = 1'b0;
        int               toggles = 0;
        int               busy_cnt = 0;
        int               last_busy_toggle = -1;
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clock);
            if (reset === 1'b1) begin
                prev_out = 1'b0;
                toggles = 0;
                busy_cnt = 0;
                last_busy_toggle = -1;
            end else begin
                if (busy === 1'b1) busy_cnt++;
                if (bounce_out !== prev_out) begin
                    toggles++;
                    if (busy === 1'b1) begin
                        if (last_busy_toggle >= 0)
                            chk("toggle_gap_min", 32'(cyc - last_busy_toggle >= MIN_PULSE), 1);
                        last_busy_toggle = cyc;
                    end
                end
                if (busy !== 1'b1) last_busy_toggle = -1;
                if (settled === 1'b1) begin
                    chk("settle_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("settle_level", bounce_out, e[48]);
                        chk("settle_cycle", cyc, e[31:0]);
                        chk("busy_cycles", busy_cnt, e[47:32]);
                        chk("edge_count", edge_count, (toggles > 255) ? 255 : toggles);
                    end
                    toggles = 0;
                    busy_cnt = 0;
                end
                if (s0_bounce_out !== s1_bounce_out || s0_edge_count !== s1_edge_count ||
                    s0_busy !== s1_busy || s0_settled !== s1_settled || s0_state !== s1_state)
                    seed_diffs++;
                prev_out = bounce_out;
            end
        end
    end

    // Directed stimulus
    initial begin
        int   start;
        int   busy_n;
        int   done;
        int   settle_at;
        int   bad;
        logic [7:0] held_count;
        logic trace [2][620];

        reset = 1'b1;
        clean_in = 1'b0;
        bounce_cycles = '0;
        clean_in_sat = 1'b0;
        bounce_cycles_sat = '0;
        repeat (3) tick();
        chk("reset_bounce_out", bounce_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_settled", settled, 0);
        chk("reset_edge_count", edge_count, 0);
        chk("reset_state", 32'(debug_state), 32'(IDLE));
        chk("reset_sat_state", 32'(sat_state), 32'(IDLE));
        reset = 1'b0;
        repeat (2) tick();

        // Clamp and saturation on the short-pulse instance
        bounce_cycles_sat = '1;
        clean_in_sat = 1'b1;
        start = cyc;
        busy_n = 0;
        done = 0;
        settle_at = 0;
        for (int i = 0; i < 2000 && done == 0; i++) begin
            tick();
            if (sat_busy === 1'b1) busy_n++;
            if (sat_settled === 1'b1) begin
                done = 1;
                settle_at = cyc;
            end
        end
        chk("sat_settled_seen", done, 1);
        chk("sat_busy_cycles", busy_n, SAT_MAX);
        chk("sat_settle_cycle", settle_at, start + SAT_MAX + 1);
        chk("sat_edge_count", sat_edge_count, 255);
        chk("sat_level", sat_bounce_out, 1);

        // Bypass, both directions
        bounce_cycles = '0;
        clean_in = 1'b1;
        push_exp(1'b1, cyc + 1, 0);
        tick();
        chk("bypass_out", bounce_out, 1);
        chk("bypass_settled", settled, 1);
        chk("bypass_busy", busy, 0);
        chk("bypass_edge_count", edge_count, 1);
        tick();
        chk("bypass_settled_pulse", settled, 0);
        clean_in = 1'b0;
        push_exp(1'b0, cyc + 1, 0);
        tick();
        chk("bypass_fall_out", bounce_out, 0);
        repeat (3) tick();

        // Full bounce window
        bounce_cycles = MAIN_WB'(1000);
        clean_in = 1'b1;
        start = cyc;
        push_exp(1'b1, start + 1001, 1000);
        tick();
        chk("bounce_first_edge", bounce_out, 1);
        chk("bounce_busy_rise", busy, 1);
        chk("bounce_state", 32'(debug_state), 32'(BOUNCE));
        chk("bounce_first_count", edge_count, 1);
        wait_settled(1100, "bounce_settle_seen");
        chk("bounce_settle_at", cyc, start + 1001);
        held_count = edge_count;
        bad = 0;
        repeat (20) begin
            tick();
            if (bounce_out !== 1'b1 || busy !== 1'b0 || settled !== 1'b0) bad++;
        end
        chk("bounce_hold_final", bad, 0);
        chk("edge_count_holds", edge_count, held_count);

        // Input change during the window
        bounce_cycles = '0;
        clean_in = 1'b0;
        push_exp(1'b0, cyc + 1, 0);
        repeat (3) tick();
        bounce_cycles = MAIN_WB'(500);
        clean_in = 1'b1;
        start = cyc;
        push_exp(1'b1, start + 501, 500);
        push_exp(1'b0, start + 1002, 500);
        repeat (190) tick();
        clean_in = 1'b0;
        wait_settled(400, "change_first_settle_seen");
        chk("change_first_level", bounce_out, 1);
        tick();
        chk("change_reevent_edge", bounce_out, 0);
        chk("change_reevent_busy", busy, 1);
        wait_settled(600, "change_second_settle_seen");
        chk("change_second_at", cyc, start + 1002);

        // Reset in the middle of a window, with clean_in high across it
        repeat (3) tick();
        bounce_cycles = MAIN_WB'(1000);
        clean_in = 1'b1;
        repeat (300) tick();
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        exp_q.delete();
        tick();
        chk("midreset_bounce_out", bounce_out, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_settled", settled, 0);
        chk("midreset_edge_count", edge_count, 0);
        tick();
        bounce_cycles = MAIN_WB'(100);
        reset = 1'b0;
        start = cyc;
        push_exp(1'b1, start + 101, 100);
        tick();
        chk("restart_edge", bounce_out, 1);
        chk("restart_busy", busy, 1);
        wait_settled(200, "restart_settle_seen");

        // Determinism: two identical runs from reset
        for (int run = 0; run < 2; run++) begin
            reset = 1'b1;
            exp_q.delete();
            clean_in = 1'b0;
            bounce_cycles = MAIN_WB'(600);
            repeat (2) tick();
            reset = 1'b0;
            repeat (2) tick();
            clean_in = 1'b1;
            start = cyc;
            push_exp(1'b1, start + 601, 600);
            for (int i = 0; i < 620; i++) begin
                tick();
                trace[run][i] = bounce_out;
            end
        end
        bad = 0;
        for (int i = 0; i < 620; i++)
            if (trace[0][i] !== trace[1][i]) bad++;
        chk("determinism_trace", bad, 0);

        chk("seed0_matches_seed1", seed_diffs, 0);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
